// File: rtl/cmp_pkg.sv
// Shared encodings for the magnitude-comparator flag consumer:
// FSM state codes and the one-hot {x,y,z} class codes.
package cmp_pkg;

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_REPORT = 1'b1
  } state_t;

  localparam logic [2:0] FLAG_GT = 3'b100;
  localparam logic [2:0] FLAG_EQ = 3'b010;
  localparam logic [2:0] FLAG_LT = 3'b001;

endpackage

// File: rtl/compare_stats_collector_if.sv
// Sample input and summary output bundle of the compare stats collector.
// master = upstream/downstream environment, slave = the collector.
interface compare_stats_collector_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             x;
  logic             y;
  logic             z;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] lt_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] max_eq_run;

  modport master (
    output in_valid, x, y, z, out_ready,
    input  in_ready, out_valid, gt_cnt, eq_cnt, lt_cnt, err_cnt, max_eq_run
  );

  modport slave (
    input  in_valid, x, y, z, out_ready,
    output in_ready, out_valid, gt_cnt, eq_cnt, lt_cnt, err_cnt, max_eq_run
  );
endinterface

// File: rtl/compare_stats_collector_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Priority: rst, then clr, then inc; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  localparam logic [W-1:0] MAX_VAL = '1;

  logic [W-1:0] q_reg;

  // Count register: clear wins over increment, increment stops at the ceiling
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (inc && (q_reg != MAX_VAL)) begin
      q_reg <= q_reg + 1'b1;
    end
  end

  assign q = q_reg;
endmodule

// File: rtl/compare_stats_collector.sv
// Collects comparator flag triples over a window of WINDOW accepted samples,
// classifies each as GT/EQ/LT/illegal, tracks the longest EQ run, and
// presents the totals as a summary record under valid/ready.
module compare_stats_collector
  import cmp_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input logic                      clk,
  input logic                      rst,
  compare_stats_collector_if.slave bus
);
  localparam int               IDX_W    = $clog2(WINDOW + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_reg;
  state_t           state_next;
  logic [IDX_W-1:0] idx_reg;
  logic [CNT_W-1:0] max_eq_run_reg;
  logic [CNT_W-1:0] cur_eq_run;
  logic [CNT_W-1:0] eq_run_inc;
  logic [CNT_W-1:0] gt_q;
  logic [CNT_W-1:0] eq_q;
  logic [CNT_W-1:0] lt_q;
  logic [CNT_W-1:0] err_q;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             accept;
  logic             report_done;
  logic             is_gt;
  logic             is_eq;
  logic             is_lt;
  logic             is_err;
  logic [2:0]       flags;

  assign flags  = {bus.x, bus.y, bus.z};
  assign is_gt  = (flags == FLAG_GT);
  assign is_eq  = (flags == FLAG_EQ);
  assign is_lt  = (flags == FLAG_LT);
  assign is_err = !(is_gt || is_eq || is_lt);

  // in_ready depends only on state, so accept has no combinational loop
  assign accept      = bus.in_valid && (state_reg == ST_ACCUM);
  assign report_done = (state_reg == ST_REPORT) && bus.out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and handshake outputs; the last accept of a window moves to REPORT
  always_comb begin
    state_next  = state_reg;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_reg)
      ST_ACCUM: begin
        in_ready_c = 1'b1;
        if (accept && (idx_reg == LAST_IDX)) begin
          state_next = ST_REPORT;
        end
      end
      ST_REPORT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_next = ST_ACCUM;
        end
      end
      default: state_next = ST_ACCUM;
    endcase
  end

  // Sample index within the window; cleared when the report is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg <= '0;
    end else if (report_done) begin
      idx_reg <= '0;
    end else if (accept) begin
      idx_reg <= idx_reg + 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk(clk), .rst(rst), .clr(report_done), .inc(accept && is_gt), .q(gt_q)
  );
  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk(clk), .rst(rst), .clr(report_done), .inc(accept && is_eq), .q(eq_q)
  );
  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk(clk), .rst(rst), .clr(report_done), .inc(accept && is_lt), .q(lt_q)
  );
  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .rst(rst), .clr(report_done), .inc(accept && is_err), .q(err_q)
  );

  // Current EQ run: any accepted non-EQ sample breaks it, idle cycles do not
  sat_counter #(.W(CNT_W)) u_cur_eq_run (
    .clk(clk),
    .rst(rst),
    .clr(report_done || (accept && !is_eq)),
    .inc(accept && is_eq),
    .q(cur_eq_run)
  );

  // Run length including the EQ sample being accepted, saturating
  assign eq_run_inc = (cur_eq_run == CNT_MAX) ? CNT_MAX : (cur_eq_run + 1'b1);

  // Longest EQ run seen in this window
  always_ff @(posedge clk) begin
    if (rst) begin
      max_eq_run_reg <= '0;
    end else if (report_done) begin
      max_eq_run_reg <= '0;
    end else if (accept && is_eq && (eq_run_inc > max_eq_run_reg)) begin
      max_eq_run_reg <= eq_run_inc;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.gt_cnt     = gt_q;
  assign bus.eq_cnt     = eq_q;
  assign bus.lt_cnt     = lt_q;
  assign bus.err_cnt    = err_q;
  assign bus.max_eq_run = max_eq_run_reg;
endmodule

// File: tb/tb_compare_stats_collector.sv
// Directed bench for compare_stats_collector: a WINDOW=4/CNT_W=8 instance for
// the main scenarios and a WINDOW=6/CNT_W=2 instance for saturation.
module tb_compare_stats_collector;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  compare_stats_collector_if #(.CNT_W(8)) b1 ();
  compare_stats_collector_if #(.CNT_W(2)) b2 ();

  compare_stats_collector #(.WINDOW(4), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  compare_stats_collector #(.WINDOW(6), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2)
  );

  // Record of dut1 as {gt, eq, lt, err, max_eq_run}
  function automatic logic [39:0] rec1();
    return {b1.gt_cnt, b1.eq_cnt, b1.lt_cnt, b1.err_cnt, b1.max_eq_run};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [2:0] f);
    b1.in_valid = 1'b1;
    {b1.x, b1.y, b1.z} = f;
    step();
    b1.in_valid = 1'b0;
  endtask

  task automatic send2(input logic [2:0] f);
    b2.in_valid = 1'b1;
    {b2.x, b2.y, b2.z} = f;
    step();
    b2.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b1.in_valid = 1'b0; b1.out_ready = 1'b0; {b1.x, b1.y, b1.z} = 3'b000;
    b2.in_valid = 1'b0; b2.out_ready = 1'b0; {b2.x, b2.y, b2.z} = 3'b000;
    step(); step();
    rst = 1'b0;
    checks++;
    if (b1.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", b1.out_valid);
    end
    checks++;
    if (b1.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", b1.in_ready);
    end
    checks++;
    if (rec1() !== 40'd0) begin
      errors++; $display("FAIL reset_record got %h want 0", rec1());
    end
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    b1.out_ready = 1'b1;
    send1(3'b100); send1(3'b010); send1(3'b010);
    checks++;
    if (b1.out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid got %b want 0", b1.out_valid);
    end
    send1(3'b001);
    checks++;
    if (b1.out_valid !== 1'b1 || b1.in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_report_hs got valid=%b ready=%b want 1/0", b1.out_valid, b1.in_ready);
    end
    checks++;
    if (rec1() !== {8'd1, 8'd2, 8'd1, 8'd0, 8'd2}) begin
      errors++; $display("FAIL basic_record got %h want 0102010002", rec1());
    end
    step();
    checks++;
    if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0 || rec1() !== 40'd0) begin
      errors++; $display("FAIL basic_after_hs got ready=%b valid=%b rec=%h want 1/0/0", b1.in_ready, b1.out_valid, rec1());
    end
    $display("test_basic: done");
  endtask

  task automatic test_illegal();
    b1.out_ready = 1'b1;
    send1(3'b110); send1(3'b000); send1(3'b010); send1(3'b001);
    checks++;
    if (b1.out_valid !== 1'b1 || rec1() !== {8'd0, 8'd1, 8'd1, 8'd2, 8'd1}) begin
      errors++; $display("FAIL illegal_record got valid=%b rec=%h want 1/0001010201", b1.out_valid, rec1());
    end
    step();
    $display("test_illegal: done");
  endtask

  task automatic test_backpressure();
    logic [39:0] held;
    b1.out_ready = 1'b0;
    send1(3'b010); send1(3'b010); send1(3'b100); send1(3'b001);
    held = {8'd1, 8'd2, 8'd1, 8'd0, 8'd2};
    checks++;
    if (b1.out_valid !== 1'b1 || rec1() !== held) begin
      errors++; $display("FAIL bp_record got valid=%b rec=%h want 1/%h", b1.out_valid, rec1(), held);
    end
    b1.in_valid = 1'b1;
    {b1.x, b1.y, b1.z} = 3'b010;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (b1.out_valid !== 1'b1 || b1.in_ready !== 1'b0 || rec1() !== held) begin
        errors++; $display("FAIL bp_hold%0d got valid=%b ready=%b rec=%h want 1/0/%h", i, b1.out_valid, b1.in_ready, rec1(), held);
      end
    end
    b1.out_ready = 1'b1;
    step();
    b1.in_valid = 1'b0;
    checks++;
    if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1 || rec1() !== 40'd0) begin
      errors++; $display("FAIL bp_release got valid=%b ready=%b rec=%h want 0/1/0", b1.out_valid, b1.in_ready, rec1());
    end
    send1(3'b001);
    checks++;
    if (rec1() !== {8'd0, 8'd0, 8'd1, 8'd0, 8'd0}) begin
      errors++; $display("FAIL bp_next_window got %h want 0000010000", rec1());
    end
    $display("test_backpressure: done");
  endtask

  task automatic test_saturation();
    b2.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send2(3'b010);
    checks++;
    if (b2.out_valid !== 1'b0) begin
      errors++; $display("FAIL sat_early_valid got %b want 0", b2.out_valid);
    end
    send2(3'b010);
    checks++;
    if (b2.out_valid !== 1'b1 || b2.eq_cnt !== 2'd3 || b2.max_eq_run !== 2'd3 || b2.gt_cnt !== 2'd0) begin
      errors++; $display("FAIL sat_record got valid=%b eq=%0d max=%0d gt=%0d want 1/3/3/0", b2.out_valid, b2.eq_cnt, b2.max_eq_run, b2.gt_cnt);
    end
    b2.out_ready = 1'b1;
    step();
    $display("test_saturation: done");
  endtask

  task automatic test_reset_mid();
    b1.out_ready = 1'b0;
    send1(3'b100); send1(3'b100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (rec1() !== 40'd0 || b1.in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_clear got rec=%h ready=%b want 0/1", rec1(), b1.in_ready);
    end
    send1(3'b010); send1(3'b010); send1(3'b010); send1(3'b001);
    checks++;
    if (b1.out_valid !== 1'b1 || rec1() !== {8'd0, 8'd3, 8'd1, 8'd0, 8'd3}) begin
      errors++; $display("FAIL rstmid_record got valid=%b rec=%h want 1/0003010003", b1.out_valid, rec1());
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (b1.out_valid !== 1'b0 || rec1() !== 40'd0) begin
      errors++; $display("FAIL rstmid_report got valid=%b rec=%h want 0/0", b1.out_valid, rec1());
    end
    $display("test_reset_mid: done");
  endtask

  task automatic test_gapped_eq();
    b1.out_ready = 1'b1;
    send1(3'b010);
    step(); step(); step();
    send1(3'b010); send1(3'b001); send1(3'b010);
    checks++;
    if (b1.out_valid !== 1'b1 || rec1() !== {8'd0, 8'd3, 8'd1, 8'd0, 8'd2}) begin
      errors++; $display("FAIL gapped_record got valid=%b rec=%h want 1/0003010002", b1.out_valid, rec1());
    end
    step();
    $display("test_gapped_eq: done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_gapped_eq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
